// File: rtl/tcdm_bank_pkg.sv
// Shared definitions for the TCDM bank adapter: FSM states, latency-pipeline
// tags, default request/response structs and the strobe-to-bitmask expansion.
// Optional feature macro used by the adapter: LAGD_BANK_RMW_EN.
package tcdm_bank_pkg;

    // Default geometry of the request/response structs below.
    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefBeWidth   = 8;

    // Upper bounds for the generic strobe expansion helper.
    localparam int unsigned MaxBeWidth   = 128;
    localparam int unsigned MaxDataWidth = 1024;
    localparam int unsigned MaxBeIdxW    = $clog2(MaxBeWidth);
    localparam int unsigned MaxDataIdxW  = $clog2(MaxDataWidth);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RMW_WAIT  = 2'd1,
        ST_RMW_WRITE = 2'd2
    } bank_state_e;

    typedef enum logic [1:0] {
        TAG_READ     = 2'd0,
        TAG_WRITE    = 2'd1,
        TAG_RMW_READ = 2'd2
    } pipe_tag_e;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic                    write;
        logic [DefDataWidth-1:0] data;
        logic [DefBeWidth-1:0]   strb;
    } tcdm_req_chan_t;

    typedef struct packed {
        logic           q_valid;
        tcdm_req_chan_t q;
    } tcdm_req_t;

    typedef struct packed {
        logic                    valid;
        logic [DefDataWidth-1:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        logic           q_ready;
        tcdm_rsp_chan_t p;
    } tcdm_rsp_t;

    // Replicate each of the low num_be strobe bits over bits_per_be mask bits.
    function automatic logic [MaxDataWidth-1:0] expand_strb(
        input logic [MaxBeWidth-1:0] strb,
        input int unsigned           bits_per_be,
        input int unsigned           num_be
    );
        logic [MaxDataWidth-1:0] mask;
        mask = '0;
        for (int unsigned b = 0; b < num_be; b++) begin
            for (int unsigned k = 0; k < bits_per_be; k++) begin
                mask[MaxDataIdxW'(b * bits_per_be + k)] = strb[MaxBeIdxW'(b)];
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/tcdm_bank_lat_pipe.sv
// Fixed-latency valid/tag shift register that mirrors the SRAM read latency,
// so each accepted request re-emerges exactly Depth cycles later.
module tcdm_bank_lat_pipe
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      valid_i,
    input  pipe_tag_e tag_i,
    output logic      valid_o,
    output pipe_tag_e tag_o
);

    for (genvar gi = 0; gi < Depth; gi++) begin : g_stage
        logic      valid_q;
        pipe_tag_e tag_q;

        if (gi == 0) begin : g_head
            // First stage captures the request issued this cycle.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    tag_q   <= TAG_READ;
                end else begin
                    valid_q <= valid_i;
                    tag_q   <= tag_i;
                end
            end
        end else begin : g_body
            // Later stages shift the previous stage forward.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    tag_q   <= TAG_READ;
                end else begin
                    valid_q <= g_stage[gi-1].valid_q;
                    tag_q   <= g_stage[gi-1].tag_q;
                end
            end
        end
    end

    assign valid_o = g_stage[Depth-1].valid_q;
    assign tag_o   = g_stage[Depth-1].tag_q;

endmodule

// File: rtl/tcdm_bank_adapter.sv
// Bank-side TCDM endpoint: turns one bank-local request stream into accesses
// on a single-port SRAM and returns in-order responses after RespLat cycles.
// Define LAGD_BANK_RMW_EN to emulate partial writes with read-modify-write
// (full-word bit mask); otherwise partial writes use the SRAM bit mask.
module tcdm_bank_adapter
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned BeWidth      = 8,
    parameter int unsigned AddrWidth    = 16,
    parameter int unsigned AddrMemWidth = 11,
    parameter int unsigned RespLat      = 1,
    parameter type         mem_req_t    = tcdm_req_t,
    parameter type         mem_rsp_t    = tcdm_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  mem_req_t                mem_req_i,
    output mem_rsp_t                mem_rsp_o,
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [AddrMemWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]    sram_wdata_o,
    output logic [DataWidth-1:0]    sram_bm_o,
    input  logic [DataWidth-1:0]    sram_rdata_i
);

    localparam int unsigned ByteOffW  = $clog2(DataWidth / 8);
    localparam int unsigned BitsPerBe = DataWidth / BeWidth;

    logic                    ready_q;
    logic                    q_ready;
    logic                    accept;
    logic                    strb_zero;
    logic [AddrMemWidth-1:0] req_addr;
    logic [DataWidth-1:0]    strb_mask;
    logic                    pipe_in_valid;
    pipe_tag_e               pipe_in_tag;
    logic                    pipe_out_valid;
    pipe_tag_e               pipe_out_tag;
    logic                    unused_addr;

    assign req_addr  = mem_req_i.q.addr[ByteOffW +: AddrMemWidth];
    assign strb_zero = (mem_req_i.q.strb == '0);
    assign strb_mask = DataWidth'(expand_strb(MaxBeWidth'(mem_req_i.q.strb), BitsPerBe, BeWidth));
    assign accept    = mem_req_i.q_valid & q_ready;

    // Byte-offset bits and bits above the word field do not select a word.
    assign unused_addr = ^{mem_req_i.q.addr[AddrWidth-1:ByteOffW+AddrMemWidth],
                           mem_req_i.q.addr[ByteOffW-1:0]};

    // Hold off grants until the first clock edge after reset releases.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

`ifdef LAGD_BANK_RMW_EN
    bank_state_e          state_q;
    logic [AddrMemWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;
    logic [BeWidth-1:0]   strb_q;
    logic [DataWidth-1:0] old_q;
    logic [DataWidth-1:0] rmw_mask;
    logic [DataWidth-1:0] merged;
    logic                 partial;

    assign partial  = mem_req_i.q.write & ~strb_zero & ~(&mem_req_i.q.strb);
    assign q_ready  = ready_q & (state_q == ST_IDLE);
    assign rmw_mask = DataWidth'(expand_strb(MaxBeWidth'(strb_q), BitsPerBe, BeWidth));
    assign merged   = (old_q & ~rmw_mask) | (data_q & rmw_mask);

    // RMW sequencer: latch the partial write, wait for the old word, write back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            old_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && partial) begin
                        addr_q  <= req_addr;
                        data_q  <= mem_req_i.q.data;
                        strb_q  <= mem_req_i.q.strb;
                        state_q <= ST_RMW_WAIT;
                    end
                end
                ST_RMW_WAIT: begin
                    // The RMW read is the youngest pipeline entry; its arrival
                    // marks the point where the old word is on sram_rdata_i.
                    if (pipe_out_valid && pipe_out_tag == TAG_RMW_READ) begin
                        old_q   <= sram_rdata_i;
                        state_q <= ST_RMW_WRITE;
                    end
                end
                ST_RMW_WRITE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // SRAM port: the RMW write-back owns the port, otherwise the accepted request.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_bm_o    = '0;
        pipe_in_valid = accept;
        pipe_in_tag   = TAG_READ;
        if (state_q == ST_RMW_WRITE) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = addr_q;
            sram_wdata_o = merged;
            sram_bm_o    = '1;
        end else if (accept) begin
            if (!mem_req_i.q.write) begin
                sram_req_o  = 1'b1;
                sram_addr_o = req_addr;
            end else if (partial) begin
                sram_req_o  = 1'b1;
                sram_addr_o = req_addr;
                pipe_in_tag = TAG_RMW_READ;
            end else begin
                pipe_in_tag = TAG_WRITE;
                if (!strb_zero) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = req_addr;
                    sram_wdata_o = mem_req_i.q.data;
                    sram_bm_o    = '1;
                end
            end
        end
    end

    // Responses: pipeline entries except RMW reads, plus the RMW write-back ack.
    always_comb begin
        mem_rsp_o         = '0;
        mem_rsp_o.q_ready = q_ready;
        mem_rsp_o.p.valid = (pipe_out_valid && pipe_out_tag != TAG_RMW_READ) ||
                            (state_q == ST_RMW_WRITE);
        mem_rsp_o.p.data  = (pipe_out_valid && pipe_out_tag == TAG_READ) ? sram_rdata_i : '0;
    end
`else
    assign q_ready = ready_q;

    // SRAM port: every accepted request maps to a single access; partial
    // writes rely on the SRAM bit mask.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_bm_o    = '0;
        pipe_in_valid = accept;
        pipe_in_tag   = mem_req_i.q.write ? TAG_WRITE : TAG_READ;
        if (accept) begin
            if (!mem_req_i.q.write) begin
                sram_req_o  = 1'b1;
                sram_addr_o = req_addr;
            end else if (!strb_zero) begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = req_addr;
                sram_wdata_o = mem_req_i.q.data;
                sram_bm_o    = strb_mask;
            end
        end
    end

    // Responses come straight from the latency pipeline.
    always_comb begin
        mem_rsp_o         = '0;
        mem_rsp_o.q_ready = q_ready;
        mem_rsp_o.p.valid = pipe_out_valid;
        mem_rsp_o.p.data  = (pipe_out_valid && pipe_out_tag == TAG_READ) ? sram_rdata_i : '0;
    end
`endif

    tcdm_bank_lat_pipe #(
        .Depth (RespLat)
    ) i_lat_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (pipe_in_valid),
        .tag_i   (pipe_in_tag),
        .valid_o (pipe_out_valid),
        .tag_o   (pipe_out_tag)
    );

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Directed bench for tcdm_bank_adapter with a behavioural 1-cycle SRAM.
// Covers both builds via LAGD_BANK_RMW_EN.
module tb_tcdm_bank_adapter;
    import tcdm_bank_pkg::*;

    logic        clk;
    logic        rst;
    tcdm_req_t   req;
    tcdm_rsp_t   rsp;
    logic        sram_req;
    logic        sram_we;
    logic [10:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_bm;
    logic [63:0] sram_rdata;

    logic [63:0] mem [2048];
    int          n_sram_writes;
    int          n_checks;
    int          n_errors;
    logic [63:0] preload [4];
    int          wr_before;

    tcdm_bank_adapter #(
        .DataWidth    (64),
        .BeWidth      (8),
        .AddrWidth    (16),
        .AddrMemWidth (11),
        .RespLat      (1),
        .mem_req_t    (tcdm_req_t),
        .mem_rsp_t    (tcdm_rsp_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_req_i    (req),
        .mem_rsp_o    (rsp),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_bm_o    (sram_bm),
        .sram_rdata_i (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        sram_rdata    = '0;
        n_sram_writes = 0;
    end

    // Behavioural SRAM: registered read, per-bit masked write.
    always @(posedge clk) begin
        if (sram_req && !sram_we) sram_rdata <= mem[sram_addr];
        if (sram_req && sram_we) begin
            mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_wdata & sram_bm);
            n_sram_writes  <= n_sram_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic w, input logic [15:0] a,
                         input logic [63:0] d, input logic [7:0] s);
        req.q_valid = v;
        req.q.write = w;
        req.q.addr  = a;
        req.q.data  = d;
        req.q.strb  = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 64'h0, 8'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        preload[0] = 64'h0000_0000_0000_1000;
        preload[1] = 64'h0123_4567_89AB_CDEF;
        preload[2] = 64'hFEDC_BA98_7654_3210;
        preload[3] = 64'hDEAD_BEEF_CAFE_F00D;
        rst = 1'b1;
        idle();

        // 1. Reset for 5 cycles: everything quiet.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_q_ready", 64'(rsp.q_ready), 64'd0);
        check("rst_p_valid", 64'(rsp.p.valid), 64'd0);
        check("rst_p_data", rsp.p.data, 64'd0);
        check("rst_sram_req", 64'(sram_req), 64'd0);
        check("rst_sram_we", 64'(sram_we), 64'd0);
        check("rst_sram_addr", 64'(sram_addr), 64'd0);
        check("rst_sram_wdata", sram_wdata, 64'd0);
        check("rst_sram_bm", sram_bm, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_q_ready", 64'(rsp.q_ready), 64'd1);

        // 2. Full write to 0x18 then read back.
        drive(1'b1, 1'b1, 16'h0018, preload[3], 8'hFF);
        #1;
        check("wr_sram_req", 64'(sram_req), 64'd1);
        check("wr_sram_we", 64'(sram_we), 64'd1);
        check("wr_sram_addr", 64'(sram_addr), 64'd3);
        check("wr_sram_wdata", sram_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        check("wr_sram_bm", sram_bm, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("wr_ack_valid", 64'(rsp.p.valid), 64'd1);
        check("wr_ack_data", rsp.p.data, 64'd0);
        drive(1'b1, 1'b0, 16'h0018, 64'h0, 8'h0);
        #1;
        check("rd_sram_req", 64'(sram_req), 64'd1);
        check("rd_sram_we", 64'(sram_we), 64'd0);
        check("rd_sram_addr", 64'(sram_addr), 64'd3);
        @(negedge clk);
        check("rd_valid", 64'(rsp.p.valid), 64'd1);
        check("rd_data", rsp.p.data, 64'hDEAD_BEEF_CAFE_F00D);
        idle();
        @(negedge clk);
        check("rd_valid_drop", 64'(rsp.p.valid), 64'd0);

        // 3. Preload words 0..2 with full writes, then four back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'(i * 8), preload[i], 8'hFF);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'(i * 8), 64'h0, 8'h0);
            #1;
            check($sformatf("b2b_addr%0d", i), 64'(sram_addr), 64'(i));
            if (i > 0) begin
                check($sformatf("b2b_valid%0d", i - 1), 64'(rsp.p.valid), 64'd1);
                check($sformatf("b2b_data%0d", i - 1), rsp.p.data, preload[i - 1]);
            end
            @(negedge clk);
        end
        idle();
        check("b2b_valid3", 64'(rsp.p.valid), 64'd1);
        check("b2b_data3", rsp.p.data, preload[3]);
        @(negedge clk);
        check("b2b_valid_drop", 64'(rsp.p.valid), 64'd0);

        // Word 8 (addr 0x40) holds 0x1111... for the partial-write cases.
        drive(1'b1, 1'b1, 16'h0040, 64'h1111_1111_1111_1111, 8'hFF);
        @(negedge clk);
        idle();
        @(negedge clk);

`ifdef LAGD_BANK_RMW_EN
        // 4. Partial write via read-modify-write.
        drive(1'b1, 1'b1, 16'h0040, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
        #1;
        check("rmw_rd_req", 64'(sram_req), 64'd1);
        check("rmw_rd_we", 64'(sram_we), 64'd0);
        check("rmw_rd_addr", 64'(sram_addr), 64'd8);
        @(negedge clk);
        idle();
        #1;
        check("rmw_wait_ready", 64'(rsp.q_ready), 64'd0);
        check("rmw_wait_valid", 64'(rsp.p.valid), 64'd0);
        check("rmw_wait_req", 64'(sram_req), 64'd0);
        @(negedge clk);
        check("rmw_wr_ready", 64'(rsp.q_ready), 64'd0);
        check("rmw_wr_req", 64'(sram_req), 64'd1);
        check("rmw_wr_we", 64'(sram_we), 64'd1);
        check("rmw_wr_addr", 64'(sram_addr), 64'd8);
        check("rmw_wr_wdata", sram_wdata, 64'h1111_1111_BBBB_BBBB);
        check("rmw_wr_bm", sram_bm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rmw_ack_valid", 64'(rsp.p.valid), 64'd1);
        check("rmw_ack_data", rsp.p.data, 64'd0);
        @(negedge clk);
        check("rmw_done_ready", 64'(rsp.q_ready), 64'd1);
        check("rmw_done_valid", 64'(rsp.p.valid), 64'd0);

        // 6. Reset during RMW_WAIT aborts the write-back.
        drive(1'b1, 1'b1, 16'h0040, 64'h2222_2222_2222_2222, 8'hF0);
        @(negedge clk);
        idle();
        wr_before = n_sram_writes;
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(rsp.p.valid), 64'd0);
        check("abort_we", 64'(sram_we), 64'd0);
        repeat (2) @(negedge clk);
        check("abort_valid_rst", 64'(rsp.p.valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid_post", 64'(rsp.p.valid), 64'd0);
        check("abort_no_write", 64'(n_sram_writes), 64'(wr_before));
        drive(1'b1, 1'b0, 16'h0040, 64'h0, 8'h0);
        @(negedge clk);
        idle();
        check("abort_rd_valid", 64'(rsp.p.valid), 64'd1);
        check("abort_rd_data", rsp.p.data, 64'h1111_1111_BBBB_BBBB);
        @(negedge clk);
`else
        // 5. Partial write uses the strobe bit mask in one cycle.
        drive(1'b1, 1'b1, 16'h0040, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
        #1;
        check("pw_ready", 64'(rsp.q_ready), 64'd1);
        check("pw_req", 64'(sram_req), 64'd1);
        check("pw_we", 64'(sram_we), 64'd1);
        check("pw_addr", 64'(sram_addr), 64'd8);
        check("pw_bm", sram_bm, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        check("pw_ack_valid", 64'(rsp.p.valid), 64'd1);
        check("pw_ack_data", rsp.p.data, 64'd0);
        drive(1'b1, 1'b0, 16'h0040, 64'h0, 8'h0);
        @(negedge clk);
        check("pw_rd_valid", 64'(rsp.p.valid), 64'd1);
        check("pw_rd_data", rsp.p.data, 64'h1111_1111_BBBB_BBBB);
        // Zero-strobe write: acknowledged, no SRAM access.
        drive(1'b1, 1'b1, 16'h0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        #1;
        check("zs_req", 64'(sram_req), 64'd0);
        @(negedge clk);
        check("zs_ack_valid", 64'(rsp.p.valid), 64'd1);
        check("zs_ack_data", rsp.p.data, 64'd0);
        drive(1'b1, 1'b0, 16'h0040, 64'h0, 8'h0);
        @(negedge clk);
        idle();
        check("zs_rd_valid", 64'(rsp.p.valid), 64'd1);
        check("zs_rd_data", rsp.p.data, 64'h1111_1111_BBBB_BBBB);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_adapter.md
# tcdm_bank_adapter

Bank-side endpoint that sits directly downstream of `tcdm_interconnect_wrap`: one instance per output port. It consumes one bank-local TCDM request stream and drives a single-port SRAM macro. It returns responses after a fixed latency and optionally performs read-modify-write for partial-strobe writes on macros without usable byte enables. It is the first stage where interconnect requests turn into real memory accesses.

## Interface
- `DataWidth`, 64: word width in bits; must be a multiple of `BeWidth`.
- `BeWidth`, 8: strobe bits; each strobe bit covers `DataWidth/BeWidth` data bits.
- `AddrWidth`, 16: width of the incoming bank-local byte address.
- `AddrMemWidth`, 11: SRAM word-address width.
- `RespLat`, 1: SRAM read latency in cycles; must be ≥1.
- `mem_req_t`, logic: request struct with fields `q_valid`, `q.addr`, `q.write`, `q.data`, `q.strb`.
- `mem_rsp_t`, logic: response struct with fields `q_ready`, `p.valid`, `p.data`.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `mem_req_i`, in, `mem_req_t`: request from the interconnect output port.
- `mem_rsp_o`, out, `mem_rsp_t`: grant and response to the interconnect.
- `sram_req_o`, out, 1: SRAM chip enable.
- `sram_we_o`, out, 1: SRAM write enable.
- `sram_addr_o`, out, `AddrMemWidth`: SRAM word address.
- `sram_wdata_o`, out, `DataWidth`: SRAM write data.
- `sram_bm_o`, out, `DataWidth`: per-bit write mask.
- `sram_rdata_i`, in, `DataWidth`: SRAM read data, valid `RespLat` cycles after the read is issued.

## Operation
- Word address: `sram_addr_o = q.addr[ByteOffW +: AddrMemWidth]`, where `ByteOffW = $clog2(DataWidth/8)`. Address bits above that field are ignored.
- A request is accepted when `q_valid & q_ready` is high in a cycle. Upstream must hold the request stable while `q_ready` is 0.
- Read accepted: issue an SRAM read the same cycle. `p.valid=1` and `p.data=sram_rdata_i` exactly `RespLat` cycles later.
- Write accepted: issue an SRAM write the same cycle. `p.valid=1` and `p.data=0` exactly `RespLat` cycles later.
- Write with `q.strb==0`: no SRAM access (`sram_req_o=0`). It is still acknowledged after `RespLat` cycles.
- Every accepted request produces exactly one `p.valid`. Responses are returned in acceptance order.
- A latency pipeline of `RespLat` stages carries, per entry, a valid bit and a tag. Tags are READ, WRITE and RMW_READ.
  - RMW_READ entries load the merge register and never raise `p.valid`.
- FSM states (RMW build only):
  - IDLE: `q_ready=1`.
  - A write with `q.strb` neither all-ones nor zero is a partial write. Accepting one issues an SRAM read of the target word, latches addr/data/strb, and moves to RMW_WAIT.
  - RMW_WAIT: `q_ready=0`. Stay `RespLat` cycles, then capture the old word and move to RMW_WRITE.
  - RMW_WRITE: `q_ready=0`. Write `merged = (old & ~mask) | (data & mask)` with an all-ones bit mask, raise `p.valid` the same cycle, then return to IDLE.
- Reads accepted before a partial write still return their own data in order. No SRAM port conflict arises, because nothing else is accepted outside IDLE.

## Timing
- Reset values: `q_ready=0`, `p.valid=0`, `p.data=0`, `sram_req_o=0`, `sram_we_o=0`, `sram_addr_o=0`, `sram_wdata_o=0`, `sram_bm_o=0`. FSM is in IDLE and the pipeline is empty.
- `q_ready` rises in the first cycle after `rst_i` deasserts.
- Throughput is one request per cycle, except partial writes in the RMW build.
- Partial write (RMW build): `q_ready` is low for `RespLat+1` cycles after acceptance. The response arrives `RespLat+1` cycles after acceptance.
- `rst_i` asserted mid-operation aborts any RMW, so no SRAM write is issued. It also flushes the pipeline, and no further `p.valid` is produced for requests accepted before reset.

## Configuration
- `LAGD_BANK_RMW_EN` defined: partial writes use the RMW FSM, and `sram_bm_o` is always all-ones on writes.
- `LAGD_BANK_RMW_EN` undefined:
  - No FSM; `q_ready` is a constant 1 after reset.
  - All writes are single-cycle, with `sram_bm_o` set to the strobe expansion (each strobe bit replicated over `DataWidth/BeWidth` bits).

## Structure
- A shared package `tcdm_bank_pkg` holds:
  - the FSM state enum (IDLE, RMW_WAIT, RMW_WRITE);
  - the pipeline tag enum;
  - the strobe-to-bitmask expansion function.
- Sub-module `tcdm_bank_lat_pipe` implements the `RespLat`-deep valid/tag shift register with asynchronous active-high clear.

## Test plan
All scenarios use `DataWidth=64`, `BeWidth=8`, `AddrMemWidth=11`, `RespLat=1`.
1. Reset: `rst_i` high for 5 cycles → all outputs 0. One cycle after deassertion, `q_ready=1`.
2. Write addr 0x18, data 0xDEADBEEF_CAFEF00D, strb 0xFF, then read 0x18 → `sram_addr_o=3`. Write ack one cycle later; read `p.data=0xDEADBEEF_CAFEF00D` one cycle after the read is accepted.
3. Back-to-back reads of 0x00, 0x08, 0x10, 0x18 in four consecutive cycles → four consecutive `p.valid` cycles in order, with SRAM addresses 0..3.
4. RMW build: word holds 0x11111111_11111111; write strb 0x0F, data 0xAAAAAAAA_BBBBBBBB → `q_ready` low 2 cycles. SRAM writes 0x11111111_BBBBBBBB and the ack arrives at acceptance+2.
5. Non-RMW build, same stimulus as scenario 4 → single-cycle write with `sram_bm_o=0x00000000_FFFFFFFF`. Zero-strobe write → no `sram_req_o`, ack after 1 cycle.
6. RMW build: assert `rst_i` during RMW_WAIT → no SRAM write and no `p.valid`. After reset, a read of the same word returns the old value.
